handshake_tx_queue: RTL and testbench

//  Parametrised CPU-side sender: buffers words from the local producer in a FIFO
//  and transmits each one to a peripheral over a 4-phase send/ack handshake.
//  The peripheral runs on its own clock, so ack is treated as asynchronous.

---
 rtl/handshake_pkg.sv | 20 ++
 rtl/handshake_tx_queue_sync_fifo.sv | 82 ++++++++
 rtl/handshake_tx_queue.sv | 154 +++++++++++++++
 tb/tb_handshake_tx_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared handshake state codes, used by this sender and the peripheral-side receiver.
package handshake_pkg;

    localparam int ESTADO_W = 3;

    localparam logic [ESTADO_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ESTADO_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ESTADO_W-1:0] ST_REQ   = 3'd2;
    localparam logic [ESTADO_W-1:0] ST_REL   = 3'd3;
    localparam logic [ESTADO_W-1:0] ST_ERR   = 3'd4;

    typedef enum logic [ESTADO_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_REQ   = ST_REQ,
        S_REL   = ST_REL,
        S_ERR   = ST_ERR
    } state_e;

endpackage

// File: rtl/handshake_tx_queue_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; the head word is always visible on rd_data.
module sync_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok_s, pop_ok_s;

    // Next-state for storage, pointers and occupancy; a push while full is dropped.
    always_comb begin
        push_ok_s = push && !full_q;
        pop_ok_s  = pop && !empty_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == {CW{1'b0}});
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/handshake_tx_queue.sv
// Queued sender: buffers producer words and ships each over a 4-phase send/ack
// handshake to a peripheral on an unrelated clock, with ack timeout and sticky error.
module handshake_tx_queue
    import handshake_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic [DATA_W-1:0]      dados,
    output logic                   send,
    input  logic                   ack,
    output logic [ESTADO_W-1:0]    estado,
    output logic                   busy,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;
    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      dados_q, dados_d;
    logic                   send_q, send_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;
    logic [TW-1:0]          tmo_q, tmo_d, tmo_inc_s;
    logic                   timeout_s;
    logic                   pop_s;
    logic [DATA_W-1:0]      head_s;
    logic                   fifo_full_s, fifo_empty_s;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop_s),
        .wr_data (wr_data),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (count)
    );

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Handshake FSM: next state, data load, pop and timeout bookkeeping.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], ack};
        state_d   = state_q;
        dados_d   = dados_q;
        err_d     = err_q;
        pop_s     = 1'b0;
        tmo_inc_s = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        timeout_s = (TIMEOUT != 0) && (tmo_inc_s == TW'(TIMEOUT));
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    dados_d = head_s;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: state_d = S_REQ;
            S_REQ: begin
                // Timeout wins over a same-cycle ack so the word stays queued for retry.
                if (timeout_s) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (ack_s && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = S_REL;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REL: begin
                if (timeout_s) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (!ack_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REL;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            tmo_d = {TW{1'b0}};
        end else if ((state_q == S_REQ) || (state_q == S_REL)) begin
            tmo_d = tmo_inc_s;
        end else begin
            tmo_d = tmo_q;
        end
        send_d = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        ovf_d  = wr_en && fifo_full_s;
    end

    // Synchroniser, FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            state_q <= S_IDLE;
            dados_q <= {DATA_W{1'b0}};
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= {TW{1'b0}};
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            dados_q <= dados_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    assign full   = fifo_full_s;
    assign ovf    = ovf_q;
    assign dados  = dados_q;
    assign send   = send_q;
    assign estado = state_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_handshake_tx_queue.sv
// Directed bench for handshake_tx_queue with a behavioural peripheral on clk or a half-rate clk2.
module tb_handshake_tx_queue;

    logic       clk;
    logic       clk2;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic [3:0] dados;
    logic       send;
    logic       ack;
    logic [2:0] estado;
    logic       busy;
    logic       err;
    logic       err_clr;

    int         checks;
    int         errors;
    int         periph_mode;
    logic [3:0] rx_q[$];
    logic [3:0] exp_q[$];

    handshake_tx_queue #(
        .DATA_W      (4),
        .DEPTH       (8),
        .SYNC_STAGES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .dados   (dados),
        .send    (send),
        .ack     (ack),
        .estado  (estado),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk2 = 1'b0;
        #3;
        forever #10 clk2 = ~clk2;
    end

    // Peripheral: mode 0 holds ack low, 1 answers after 2 clk cycles, 2 answers on clk2 with random delay.
    initial begin
        ack = 1'b0;
        forever begin
            if (periph_mode == 2) begin
                @(posedge clk2); #1;
            end else begin
                @(posedge clk); #1;
            end
            if (periph_mode == 0) begin
                ack = 1'b0;
            end else if (!ack && send) begin
                if (periph_mode == 2) repeat ($urandom_range(0, 2)) @(posedge clk2);
                else repeat (2) @(posedge clk);
                #1;
                rx_q.push_back(dados);
                ack = 1'b1;
            end else if (ack && !send) begin
                if (periph_mode == 2) repeat ($urandom_range(0, 2)) @(posedge clk2);
                else repeat (2) @(posedge clk);
                #1;
                ack = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget && !(estado == 3'd0 && ack == 1'b0); k++) tick();
        checks++;
        if (!(estado == 3'd0 && ack == 1'b0)) begin
            errors++;
            $display("FAIL wait_idle: estado=%0d ack=%0b after %0d cycles, required estado=0 ack=0", estado, ack, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #20;
        checks++;
        if ({send, dados, count, estado, err, busy, ovf, full} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: send=%0b dados=%0h count=%0d estado=%0d err=%0b busy=%0b ovf=%0b full=%0b, required all 0",
                     send, dados, count, estado, err, busy, ovf, full);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (estado !== 3'd0 || send !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: estado=%0d send=%0b, required 0/0", estado, send);
        end
    endtask

    task automatic test_single();
        int k;
        rx_q.delete();
        periph_mode = 1;
        wr_en = 1'b1; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        checks++;
        if (count !== 4'd1 || estado !== 3'd0 || send !== 1'b0) begin
            errors++;
            $display("FAIL single_push: count=%0d estado=%0d send=%0b, required 1/0/0", count, estado, send);
        end
        tick();
        checks++;
        if (dados !== 4'hA || estado !== 3'd1 || send !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_setup: dados=%0h estado=%0d send=%0b busy=%0b, required a/1/0/1", dados, estado, send, busy);
        end
        tick();
        checks++;
        if (send !== 1'b1 || estado !== 3'd2 || dados !== 4'hA) begin
            errors++;
            $display("FAIL single_req: send=%0b estado=%0d dados=%0h, required 1/2/a", send, estado, dados);
        end
        for (k = 0; k < 30 && count != 4'd0; k++) tick();
        checks++;
        if (count !== 4'd0 || estado !== 3'd3 || send !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: count=%0d estado=%0d send=%0b, required 0/3/0", count, estado, send);
        end
        wait_idle(40);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 4'hA) begin
            errors++;
            $display("FAIL single_rx: received %0d words first=%0h, required 1 word a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 4'h0);
        end
    endtask

    task automatic test_burst_full();
        int k;
        rx_q.delete();
        periph_mode = 0;
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1; wr_data = 4'(i);
            tick();
            if (i == 8) begin
                checks++;
                if (full !== 1'b1 || count !== 4'd8 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_full: full=%0b count=%0d ovf=%0b, required 1/8/0", full, count, ovf);
                end
            end
        end
        wr_en = 1'b0;
        checks++;
        if (ovf !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL burst_ovf: ovf=%0b count=%0d, required 1/8", ovf, count);
        end
        tick();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL burst_ovf_pulse: ovf=%0b, required 0", ovf);
        end
        periph_mode = 1;
        for (k = 0; k < 500 && !(rx_q.size() == 8 && count == 4'd0); k++) tick();
        wait_idle(40);
        checks++;
        if (rx_q.size() != 8 || count !== 4'd0) begin
            errors++;
            $display("FAIL burst_rx_count: received %0d count=%0d, required 8/0", rx_q.size(), count);
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 4'(i + 1)) begin
                errors++;
                $display("FAIL burst_order[%0d]: got %0h, required %0h", i, rx_q[i], i + 1);
            end
        end
    endtask

    task automatic test_timeout();
        rx_q.delete();
        periph_mode = 0;
        wr_en = 1'b1; wr_data = 4'h5;
        tick();
        wr_en = 1'b0;
        repeat (17) tick();
        checks++;
        if (estado !== 3'd2 || send !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_req_held: estado=%0d send=%0b err=%0b, required 2/1/0", estado, send, err);
        end
        tick();
        checks++;
        if (estado !== 3'd4 || send !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: estado=%0d send=%0b err=%0b, required 4/0/1", estado, send, err);
        end
        repeat (3) tick();
        checks++;
        if (estado !== 3'd4 || err !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL timeout_sticky: estado=%0d err=%0b count=%0d, required 4/1/1", estado, err, count);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (estado !== 3'd0 || err !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL timeout_clear: estado=%0d err=%0b count=%0d, required 0/0/1", estado, err, count);
        end
        periph_mode = 1;
        for (int k = 0; k < 60 && rx_q.size() == 0; k++) tick();
        wait_idle(60);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 4'h5 || count !== 4'd0) begin
            errors++;
            $display("FAIL timeout_resend: received %0d words first=%0h count=%0d, required 1 word 5, count 0",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 4'h0, count);
        end
    endtask

    task automatic test_async_peripheral();
        int k;
        int bad;
        rx_q.delete();
        exp_q.delete();
        periph_mode = 2;
        for (int i = 0; i < 100; i++) begin
            for (k = 0; k < 200 && full; k++) tick();
            wr_en = 1'b1;
            wr_data = 4'($urandom_range(0, 15));
            exp_q.push_back(wr_data);
            tick();
            wr_en = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (k = 0; k < 6000 && !(rx_q.size() >= 100 && count == 4'd0 && estado == 3'd0 && ack == 1'b0); k++) tick();
        periph_mode = 0;
        checks++;
        if (rx_q.size() != 100 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_count: received %0d err=%0b, required 100/0", rx_q.size(), err);
        end
        bad = 0;
        for (int i = 0; i < 100 && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL async_data: %0d words out of order or corrupted, required 0", bad);
        end
    endtask

    task automatic test_reset_midflight();
        int sends;
        rx_q.delete();
        periph_mode = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 4'(4'hC + i);
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (estado !== 3'd2 || send !== 1'b1 || count !== 4'd3) begin
            errors++;
            $display("FAIL midreset_setup: estado=%0d send=%0b count=%0d, required 2/1/3", estado, send, count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (send !== 1'b0 || count !== 4'd0 || estado !== 3'd0) begin
            errors++;
            $display("FAIL midreset_async: send=%0b count=%0d estado=%0d, required 0/0/0", send, count, estado);
        end
        #2 rst = 1'b1;
        periph_mode = 1;
        sends = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (send) sends++;
        end
        checks++;
        if (sends != 0 || rx_q.size() != 0 || count !== 4'd0) begin
            errors++;
            $display("FAIL midreset_discard: send cycles=%0d received=%0d count=%0d, required 0/0/0", sends, rx_q.size(), count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        periph_mode = 0;
        wr_en = 1'b0;
        wr_data = 4'h0;
        err_clr = 1'b0;
        test_reset();
        test_single();
        test_burst_full();
        test_timeout();
        test_async_peripheral();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
